// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter. It sends one byte as a start bit, eight data
//               bits LSB-first, an optional even-parity bit and one stop bit.
//               Each bit lasts DIV = CLK_FREQ/BAUD_RATE clock cycles.
//               All outputs are registered.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between
//               the data bits and the stop bit (8E1). Without it the frame is
//               8N1.
// Ports       : clk      - clock; all state updates on the rising edge
//               reset    - asynchronous, active-high reset
//               start    - send request; a one-cycle pulse or a held level
//               tx_data  - byte to send, sampled only when a start is accepted
//               tx       - serial line; idles high
//               tx_busy  - high while a frame is in progress
//               tx_done  - one-cycle pulse on the first idle cycle after a frame
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int C_DIV   = CLK_FREQ / BAUD_RATE;
    localparam int C_CNT_W = (C_DIV > 1) ? $clog2(C_DIV) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;
`endif

    state_t               r_state,   w_state_next;
    logic [C_CNT_W-1:0]   r_baud,    w_baud_next;
    logic [2:0]           r_bit_idx, w_bit_idx_next;
    logic [7:0]           r_shift,   w_shift_next;
    logic                 r_tx,      w_tx_next;
    logic                 r_busy,    w_busy_next;
    logic                 r_done,    w_done_next;
    logic                 w_baud_wrap;

    assign w_baud_wrap = (r_baud == C_CNT_LAST);

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next   = r_state;
        w_baud_next    = r_baud + C_CNT_W'(1);
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_done_next    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                if (start) begin
                    w_shift_next = tx_data;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_baud_wrap) begin
                    w_baud_next    = '0;
                    w_bit_idx_next = 3'd0;
                    w_state_next   = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_wrap) begin
                    w_baud_next = '0;
                    // The index wraps 7 -> 0 as the last data bit ends.
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baud_wrap) begin
                    w_baud_next  = '0;
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_baud_wrap) begin
                    w_baud_next  = '0;
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_baud_next  = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output values are decoded from the next state so that the registered
    // line level changes in the same cycle the state does.
    always_comb begin
        w_tx_next   = 1'b1;
        w_busy_next = 1'b1;
        case (w_state_next)
            S_IDLE:   w_busy_next = 1'b0;
            S_START:  w_tx_next   = 1'b0;
            S_DATA:   w_tx_next   = w_shift_next[w_bit_idx_next];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_next   = ^w_shift_next;
`endif
            S_STOP:   w_tx_next   = 1'b1;
            default: begin
                w_tx_next   = 1'b1;
                w_busy_next = 1'b0;
            end
        endcase
    end

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx with CLK_FREQ=160 and
//               BAUD_RATE=10, which gives 16 cycles per bit. Inputs are driven
//               on the falling edge and outputs are sampled there as well.
//               Define UART_TX_PARITY_EN for both files to test the 8E1 build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int C_DIV = 16;
`ifdef UART_TX_PARITY_EN
    localparam int C_SLOTS = 11;
`else
    localparam int C_SLOTS = 10;
`endif
    localparam int C_FRAME = C_SLOTS * C_DIV;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx #(
        .CLK_FREQ  (160),
        .BAUD_RATE (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .tx_data (tx_data),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge. The start pulse is seen on the next rising
    // edge, so the call returns at the falling edge of frame cycle 0.
    task automatic launch(input logic [7:0] data);
        start   = 1'b1;
        tx_data = data;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Checks one full frame starting at frame cycle 0. The frame should have
    // exact slot lengths, tx_busy high, no early tx_done, and a decoded byte
    // and parity bit that match. At cycle inj a stray start pulse with 8'hFF
    // is issued. If chain is set, the next byte is started on the done cycle.
    task automatic run_frame(input string tag, input logic [7:0] exp, input logic exp_par,
                             input int inj, input bit chain, input logic [7:0] chain_data);
        int         bad_tx;
        int         bad_busy;
        int         bad_done;
        int         slot;
        logic       exp_bit;
        logic [7:0] dec;
        logic       par_obs;
        bad_tx   = 0;
        bad_busy = 0;
        bad_done = 0;
        dec      = 8'h00;
        par_obs  = 1'b0;
        for (int k = 0; k < C_FRAME; k++) begin
            slot = k / C_DIV;
            if (slot == 0)
                exp_bit = 1'b0;
            else if (slot <= 8)
                exp_bit = exp[slot-1];
            else if (slot == C_SLOTS - 1)
                exp_bit = 1'b1;
            else
                exp_bit = exp_par;
            if (tx !== exp_bit)   bad_tx++;
            if (tx_busy !== 1'b1) bad_busy++;
            if (tx_done !== 1'b0) bad_done++;
            if ((k % C_DIV) == C_DIV / 2) begin
                if (slot >= 1 && slot <= 8) dec[slot-1] = tx;
                if (slot == 9)              par_obs     = tx;
            end
            start = (k == inj);
            if (k == inj) tx_data = 8'hFF;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_tx_bits"},    bad_tx,   0);
        check({tag, "_busy_frame"}, bad_busy, 0);
        check({tag, "_done_early"}, bad_done, 0);
        check({tag, "_decoded"},    {24'h0, dec}, {24'h0, exp});
`ifdef UART_TX_PARITY_EN
        check({tag, "_parity"},     {31'h0, par_obs}, {31'h0, exp_par});
`endif
        check({tag, "_done_pulse"}, {31'h0, tx_done}, 1);
        check({tag, "_busy_done"},  {31'h0, tx_busy}, 0);
        check({tag, "_tx_done"},    {31'h0, tx},      1);
        if (chain) begin
            launch(chain_data);
        end else begin
            @(negedge clk);
            check({tag, "_done_once"}, {31'h0, tx_done}, 0);
            check({tag, "_idle_tx"},   {31'h0, tx},      1);
        end
    endtask

    initial begin
        int idle_bad;
        reset   = 1'b1;
        start   = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx",   {31'h0, tx},      1);
        check("rst_busy", {31'h0, tx_busy}, 0);
        check("rst_done", {31'h0, tx_done}, 0);
        reset = 1'b0;

        // No start for 100 cycles after reset is released
        idle_bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) idle_bad++;
        end
        check("idle_100", idle_bad, 0);

        // Single frame: 8'h30 has two ones, so even parity is 0
        launch(8'h30);
        run_frame("b30", 8'h30, 1'b0, -1, 1'b0, 8'h00);

        // Back-to-back: 8'h32 is started on the done cycle of 8'h31
        launch(8'h31);
        run_frame("b31", 8'h31, 1'b1, -1, 1'b1, 8'h32);
        run_frame("b32", 8'h32, 1'b1, -1, 1'b0, 8'h00);

        // A start pulse mid-frame must be ignored
        launch(8'h41);
        run_frame("b41", 8'h41, 1'b0, 40, 1'b0, 8'h00);

        // Reset asserted mid-frame
        launch(8'h55);
        repeat (70) @(negedge clk);
        check("pre_rst_busy", {31'h0, tx_busy}, 1);
        reset = 1'b1;
        #1;
        check("abort_tx",   {31'h0, tx},      1);
        check("abort_busy", {31'h0, tx_busy}, 0);
        idle_bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (tx_done !== 1'b0 || tx !== 1'b1) idle_bad++;
        end
        reset = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx_done !== 1'b0 || tx !== 1'b1 || tx_busy !== 1'b0) idle_bad++;
        end
        check("abort_no_done", idle_bad, 0);

        // The first start after reset is accepted normally
        launch(8'h55);
        run_frame("b55", 8'h55, 1'b0, -1, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop if the main sequence stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
